// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared FSM encoding, error codes and word width for the program loader
package program_loader_pkg;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_CSUM    = 2'b11;
endpackage

// File: rtl/program_loader_word_assembler.sv
// loader_word_assembler: packs four stream bytes MSB-first into one instruction word
module loader_word_assembler
    import program_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [7:0]        byte_i,
    output logic              word_ready_o,
    output logic [WORD_W-1:0] word_o
);
    logic [1:0]  cnt_q;
    logic [23:0] sh_q;

    // byte counter and shift register; cleared outside DATA so a partial word never leaks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 2'd0;
            sh_q  <= 24'd0;
        end else if (clr_i) begin
            cnt_q <= 2'd0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 2'd1;
            sh_q  <= {sh_q[15:0], byte_i};
        end
    end

    // the fourth byte completes the word in the same cycle it is accepted
    always_comb begin
        word_ready_o = en_i && (cnt_q == 2'd3);
        word_o       = {sh_q, byte_i};
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: loads a length-prefixed byte image into program memory and releases the core
// Optional trailing XOR checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MEMORY_DEPTH   = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [WORD_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_data_o,
    output logic              cpu_reset_n_o,
    output logic              done_o,
    output logic              error_o,
    output logic [1:0]        err_code_o
);
    localparam int          TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] DEPTH = 17'(MEMORY_DEPTH);

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [1:0]  err_q, err_d;
    logic        we_q;
    logic [WORD_W-1:0] addr_q, data_q;
    logic        accept, restart, timeout, last, word_ready;
    logic [15:0] n;
    logic [WORD_W-1:0] word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
    localparam state_t S_AFTER = S_CSUM;
`else
    localparam state_t S_AFTER = S_DONE;
`endif

    assign accept  = byte_ready_o && byte_valid_i;
    assign restart = start_i && (state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign n       = {len_q[15:8], byte_i};
    assign timeout = byte_ready_o && !accept && (idle_q == TW'(TIMEOUT_CYCLES - 1));
    assign last    = (idx_q == len_q - 16'd1);

    loader_word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (state_q != S_DATA),
        .en_i         (accept && state_q == S_DATA),
        .byte_i       (byte_i),
        .word_ready_o (word_ready),
        .word_o       (word)
    );

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next-state: restart wins, then timeout, then byte-driven progress
    always_comb begin
        state_d = state_q;
        if (restart) state_d = S_LEN_HI;
        else if (timeout) state_d = S_ERROR;
        else if (accept) begin
            case (state_q)
                S_LEN_HI: state_d = S_LEN_LO;
                S_LEN_LO: state_d = (n == 16'd0) ? S_DONE : ({1'b0, n} > DEPTH) ? S_ERROR : S_DATA;
                S_DATA:   state_d = (word_ready && last) ? S_AFTER : S_DATA;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                S_CSUM:   state_d = (byte_i == csum_q) ? S_DONE : S_ERROR;
`endif
                default:  state_d = state_q;
            endcase
        end
    end

    // outputs decoded from registered state only
    always_comb begin
        byte_ready_o  = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
        done_o        = (state_q == S_DONE);
        cpu_reset_n_o = (state_q == S_DONE);
        error_o       = (state_q == S_ERROR);
    end

    // datapath next values: length capture, word index, idle counter, error code
    always_comb begin
        len_d  = len_q;
        idx_d  = idx_q;
        err_d  = err_q;
        idle_d = (byte_ready_o && !accept) ? TW'(idle_q + 1'b1) : '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d = csum_q;
`endif
        if (restart) begin
            len_d = 16'd0;
            idx_d = 16'd0;
            err_d = ERR_NONE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_d = 8'd0;
`endif
        end else begin
            if (accept && state_q == S_LEN_HI) len_d = {byte_i, 8'h00};
            if (accept && state_q == S_LEN_LO) len_d = n;
            if (word_ready) idx_d = idx_q + 16'd1;
            if (timeout) err_d = ERR_TIMEOUT;
            else if (accept && state_q == S_LEN_LO && {1'b0, n} > DEPTH) err_d = ERR_LEN;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (accept && state_q != S_CSUM) csum_d = csum_q ^ byte_i;
            if (accept && state_q == S_CSUM && byte_i != csum_q) err_d = ERR_CSUM;
`endif
        end
    end

    // datapath registers plus the one-cycle write strobe with its address and data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q  <= 16'd0;
            idx_q  <= 16'd0;
            idle_q <= '0;
            err_q  <= ERR_NONE;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q <= 8'd0;
`endif
        end else begin
            len_q  <= len_d;
            idx_q  <= idx_d;
            idle_q <= idle_d;
            err_q  <= err_d;
            we_q   <= word_ready;
            if (word_ready) begin
                addr_q <= {14'd0, idx_q, 2'b00};
                data_q <= word;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q <= csum_d;
`endif
        end
    end

    assign mem_we_o   = we_q;
    assign mem_addr_o = addr_q;
    assign mem_data_o = data_q;
    assign err_code_o = err_q;
endmodule
